// File: rtl/reg_write_scheduler.sv
// rtl/reg_write_scheduler.sv - register-file write port arbiter: unstallable ALU writeback plus FIFO-buffered load writeback
// Each entry's live bit is cleared by a pop or by a WAW kill from a younger ALU write to the same register.

module reg_write_scheduler #(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = 16,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              AluWre,
   input  logic [3:0]        AluReg,
   input  logic [DATA_W-1:0] AluData,
   input  logic              MemValid,
   output logic              MemReady,
   input  logic [3:0]        MemReg,
   input  logic [DATA_W-1:0] MemData,
   output logic              RegWre,
   output logic [3:0]        WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic [15:0]       PendingMask,
   output logic [AW:0]       FifoCount
);

   logic [3:0]        fifo_reg  [DEPTH];
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [DEPTH-1:0]  live;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              ready_en;

   logic alu_go;
   logic mem_acc;
   logic empty;
   logic pop;
   logic bypass;
   logic push;

   assign MemReady  = ready_en && (count != (AW+1)'(DEPTH));
   assign FifoCount = count;

   assign alu_go  = AluWre && (AluReg != 4'd0);
   assign mem_acc = MemValid && MemReady;
   assign empty   = (count == '0);
   assign pop     = !alu_go && !empty;
   assign bypass  = !alu_go && empty && mem_acc;
   // Loads to r0 complete the handshake but are never stored.
   assign push    = mem_acc && (MemReg != 4'd0) && !bypass;

   always_comb begin
      PendingMask = '0;
      for (int i = 0; i < DEPTH; i++)
         if (live[i])
            PendingMask[fifo_reg[i]] = 1'b1;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ready_en  <= 1'b0;
         live      <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         RegWre    <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_reg[i]  <= '0;
            fifo_data[i] <= '0;
         end
      end else begin
         ready_en <= 1'b1;

         if (alu_go)
            for (int i = 0; i < DEPTH; i++)
               if (fifo_reg[i] == AluReg)
                  live[i] <= 1'b0;

         if (pop) begin
            live[rd_ptr] <= 1'b0;
            rd_ptr       <= rd_ptr + 1'b1;
         end

         // Applied after the kill loop so a same-edge load to the killed register stays live.
         if (push) begin
            fifo_reg[wr_ptr]  <= MemReg;
            fifo_data[wr_ptr] <= MemData;
            live[wr_ptr]      <= 1'b1;
            wr_ptr            <= wr_ptr + 1'b1;
         end

         count <= count + (AW+1)'(push) - (AW+1)'(pop);

         if (alu_go) begin
            RegWre    <= 1'b1;
            WriteReg  <= AluReg;
            WriteData <= AluData;
         end else if (pop) begin
            RegWre <= live[rd_ptr];
            if (live[rd_ptr]) begin
               WriteReg  <= fifo_reg[rd_ptr];
               WriteData <= fifo_data[rd_ptr];
            end
         end else if (bypass && (MemReg != 4'd0)) begin
            RegWre    <= 1'b1;
            WriteReg  <= MemReg;
            WriteData <= MemData;
         end else begin
            RegWre <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_reg_write_scheduler.sv
// tb/tb_reg_write_scheduler.sv - scoreboard bench for reg_write_scheduler
// Expected writes are queued in issue order; the negedge monitor pops and compares each RegWre pulse.

module tb_reg_write_scheduler;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        AluWre;
   logic [3:0]  AluReg;
   logic [15:0] AluData;
   logic        MemValid;
   logic        MemReady;
   logic [3:0]  MemReg;
   logic [15:0] MemData;
   logic        RegWre;
   logic [3:0]  WriteReg;
   logic [15:0] WriteData;
   logic [15:0] PendingMask;
   logic [2:0]  FifoCount;

   int vectors     = 0;
   int miscompares = 0;
   logic [19:0] exp_q [$];

   always #5 Clk = ~Clk;

   reg_write_scheduler #(.DEPTH(4), .DATA_W(16)) dut (
      .Clk(Clk), .Rst(Rst),
      .AluWre(AluWre), .AluReg(AluReg), .AluData(AluData),
      .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
      .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
      .PendingMask(PendingMask), .FifoCount(FifoCount)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_wr(input logic [3:0] r, input logic [15:0] d);
      exp_q.push_back({r, d});
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic offer_load(input logic [3:0] r, input logic [15:0] d);
      logic rdy;
      MemValid = 1'b1;
      MemReg   = r;
      MemData  = d;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clk);
         rdy = MemReady;
         step();
         if (rdy) begin
            MemValid = 1'b0;
            return;
         end
      end
      MemValid = 1'b0;
      chk("load_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 40 && exp_q.size() != 0; k++)
         @(posedge Clk);
      repeat (3) @(posedge Clk);
      #1;
      chk({"drain_", tag}, exp_q.size(), 0);
   endtask

   always @(negedge Clk) begin
      if (RegWre) begin
         if (exp_q.size() == 0)
            chk("unexpected_write", {12'd0, WriteReg, WriteData}, 32'd0);
         else
            chk("write", {12'd0, WriteReg, WriteData}, {12'd0, exp_q.pop_front()});
      end
   end

   initial begin
      Rst = 1'b1; AluWre = 1'b0; AluReg = '0; AluData = '0;
      MemValid = 1'b0; MemReg = '0; MemData = '0;

      repeat (2) step();
      @(negedge Clk);
      chk("rst_regwre", RegWre, 0);
      chk("rst_ready", MemReady, 0);
      chk("rst_mask", PendingMask, 0);
      chk("rst_count", FifoCount, 0);
      step();
      Rst = 1'b0;
      @(negedge Clk);
      chk("ready_before_edge", MemReady, 0);
      step();
      chk("ready_after_edge", MemReady, 1);

      // Bypass
      expect_wr(4'd3, 16'h1234);
      offer_load(4'd3, 16'h1234);
      @(negedge Clk);
      chk("bypass_count", FifoCount, 0);
      wait_drain("bypass");

      // Contention: six ALU writes while five loads are offered
      for (int i = 0; i < 6; i++) expect_wr(4'(i + 1), 16'hA000 + 16'(i));
      for (int j = 0; j < 5; j++) expect_wr(4'(8 + j), 16'hB000 + 16'(j));
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               AluWre = 1'b1; AluReg = 4'(i + 1); AluData = 16'hA000 + 16'(i);
               step();
            end
            AluWre = 1'b0;
            @(negedge Clk);
            chk("full_count", FifoCount, 4);
            chk("full_ready", MemReady, 0);
            chk("full_mask", PendingMask, 16'h0F00);
         end
         begin
            for (int j = 0; j < 5; j++) offer_load(4'(8 + j), 16'hB000 + 16'(j));
         end
      join
      wait_drain("contention");

      // WAW kill
      expect_wr(4'd6, 16'h0066);
      expect_wr(4'd5, 16'h0055);
      AluWre = 1'b1; AluReg = 4'd6; AluData = 16'h0066;
      MemValid = 1'b1; MemReg = 4'd5; MemData = 16'hAAAA;
      step();
      MemValid = 1'b0;
      AluReg = 4'd5; AluData = 16'h0055;
      @(negedge Clk);
      chk("kill_mask_before", PendingMask, 16'h0020);
      step();
      AluWre = 1'b0;
      @(negedge Clk);
      chk("kill_mask_after", PendingMask, 16'h0000);
      chk("kill_count", FifoCount, 1);
      step();
      @(negedge Clk);
      chk("kill_bubble", RegWre, 0);
      chk("kill_popped", FifoCount, 0);
      wait_drain("kill");

      // Same-edge ALU and load to r2: the load is younger and survives
      expect_wr(4'd2, 16'h2222);
      expect_wr(4'd2, 16'h3333);
      AluWre = 1'b1; AluReg = 4'd2; AluData = 16'h2222;
      MemValid = 1'b1; MemReg = 4'd2; MemData = 16'h3333;
      step();
      AluWre = 1'b0; MemValid = 1'b0;
      @(negedge Clk);
      chk("same_edge_mask", PendingMask, 16'h0004);
      wait_drain("same_edge");

      // Register 0 on both sources
      AluWre = 1'b1; AluReg = 4'd0; AluData = 16'hDEAD;
      MemValid = 1'b1; MemReg = 4'd0; MemData = 16'hBEEF;
      @(negedge Clk);
      chk("r0_handshake", MemReady, 1);
      step();
      AluWre = 1'b0; MemValid = 1'b0;
      @(negedge Clk);
      chk("r0_no_write", RegWre, 0);
      chk("r0_count", FifoCount, 0);
      expect_wr(4'd7, 16'h0777);
      AluWre = 1'b1; AluReg = 4'd7; AluData = 16'h0777;
      MemValid = 1'b1; MemReg = 4'd0; MemData = 16'hBEEF;
      step();
      AluWre = 1'b0; MemValid = 1'b0;
      @(negedge Clk);
      chk("r0_behind_alu_count", FifoCount, 0);
      wait_drain("r0");

      // Reset with three entries queued
      for (int i = 0; i < 3; i++) expect_wr(4'(i + 1), 16'hC000 + 16'(i));
      for (int i = 0; i < 3; i++) begin
         AluWre = 1'b1; AluReg = 4'(i + 1); AluData = 16'hC000 + 16'(i);
         MemValid = 1'b1; MemReg = 4'(9 + i); MemData = 16'hD000 + 16'(i);
         step();
      end
      AluWre = 1'b0; MemValid = 1'b0;
      @(negedge Clk);
      chk("pre_rst_count", FifoCount, 3);
      #1 Rst = 1'b1;
      #1;
      chk("mid_rst_count", FifoCount, 0);
      chk("mid_rst_mask", PendingMask, 0);
      chk("mid_rst_regwre", RegWre, 0);
      chk("mid_rst_ready", MemReady, 0);
      repeat (2) step();
      Rst = 1'b0;
      repeat (10) step();
      chk("post_rst_queue", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
